// File: rtl/mmio_slot_fabric.sv
// MMIO slot fabric: decodes the FPro MMIO bus into N_SLOT slots, registers read data and logs unmapped accesses.
// Optional per-slot access counters are enabled by defining MMIO_ACCESS_CNT_EN.
module mmio_slot_fabric #(
  parameter int unsigned N_SLOT      = 8,
  parameter int unsigned STAT_SLOT   = 63,
  parameter logic [31:0] UNMAPPED_RD = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mmio_cs,
  input  logic                   mmio_wr,
  input  logic                   mmio_rd,
  input  logic [20:0]            mmio_addr,
  input  logic [31:0]            mmio_wr_data,
  output logic [31:0]            mmio_rd_data,
  output logic                   mmio_rd_valid,
  output logic [N_SLOT-1:0]      slot_cs,
  output logic [N_SLOT-1:0]      slot_rd,
  output logic [N_SLOT-1:0]      slot_wr,
  output logic [4:0]             slot_reg_addr,
  output logic [31:0]            slot_wr_data,
  input  logic [32*N_SLOT-1:0]   slot_rd_data
);
  localparam int unsigned SW = 6;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;
`ifdef MMIO_ACCESS_CNT_EN
  localparam int unsigned N_CNT = (N_SLOT < 16) ? N_SLOT : 16;
`endif

  logic [SW-1:0] sel;
  logic [RW-1:0] reg_sel;
  logic          is_stat;
  logic          is_mapped;
  logic          rd_req;
  logic          unmapped_acc;
  logic          viol;
  logic          stat_clr;
  logic [DW-1:0] slot_word;
  logic [DW-1:0] stat_word;
  logic [DW-1:0] rd_word;
  logic [CW-1:0] err_count;
  logic [DW-1:0] err_info;
  logic          unused_addr;

  assign sel           = mmio_addr[10:5];
  assign reg_sel       = mmio_addr[4:0];
  assign unused_addr   = ^mmio_addr[20:11];
  assign is_stat       = (sel == SW'(STAT_SLOT));
  assign is_mapped     = (sel < SW'(N_SLOT));
  assign rd_req        = mmio_cs & mmio_rd & ~mmio_wr;
  assign unmapped_acc  = mmio_cs & (mmio_rd | mmio_wr) & ~is_mapped & ~is_stat;
  assign viol          = mmio_cs & mmio_rd & mmio_wr & ~is_stat;
  assign stat_clr      = mmio_cs & mmio_wr & is_stat & (reg_sel == RW'(2));
  assign slot_reg_addr = reg_sel;
  assign slot_wr_data  = mmio_wr_data;

  // Per-slot strobes; unmapped and status-slot selects match no index.
  always_comb begin
    slot_cs = '0;
    slot_rd = '0;
    slot_wr = '0;
    for (int unsigned i = 0; i < N_SLOT; i++) begin
      slot_cs[i] = mmio_cs & (sel == SW'(i));
      slot_rd[i] = slot_cs[i] & mmio_rd & ~mmio_wr;
      slot_wr[i] = slot_cs[i] & mmio_wr;
    end
  end

  always_comb begin
    slot_word = '0;
    for (int unsigned i = 0; i < N_SLOT; i++) begin
      if (sel == SW'(i)) slot_word = slot_rd_data[DW*i +: DW];
    end
  end

`ifdef MMIO_ACCESS_CNT_EN
  logic [CW-1:0] acc_cnt [N_CNT];

  // Saturating access counters, one per low-numbered slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_CNT; i++) acc_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int unsigned i = 0; i < N_CNT; i++) acc_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if ((slot_rd[i] | slot_wr[i]) && (acc_cnt[i] != '1)) acc_cnt[i] <= acc_cnt[i] + CW'(1);
      end
    end
  end
`endif

  always_comb begin
    stat_word = '0;
    case (reg_sel)
      RW'(0):  stat_word = {16'h0, err_count};
      RW'(1):  stat_word = err_info;
      RW'(3):  stat_word = DW'(N_SLOT);
      default: stat_word = '0;
    endcase
`ifdef MMIO_ACCESS_CNT_EN
    if (reg_sel[4]) begin
      for (int unsigned i = 0; i < N_CNT; i++) begin
        if (reg_sel[3:0] == 4'(i)) stat_word = {16'h0, acc_cnt[i]};
      end
    end
`endif
  end

  assign rd_word = is_stat ? stat_word : (is_mapped ? slot_word : UNMAPPED_RD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_rd_data  <= '0;
      mmio_rd_valid <= 1'b0;
    end else begin
      mmio_rd_valid <= rd_req;
      if (rd_req) mmio_rd_data <= rd_word;
    end
  end

  // Error log; a clear is itself a status access so it never races a new error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
      err_info  <= '0;
    end else if (stat_clr) begin
      err_count <= '0;
      err_info  <= '0;
    end else begin
      if (viol) err_info[30] <= 1'b1;
      if (unmapped_acc) begin
        if (err_count != '1) err_count <= err_count + CW'(1);
        err_info[31]   <= 1'b1;
        err_info[11]   <= mmio_wr;
        err_info[10:0] <= mmio_addr[10:0];
      end
    end
  end
endmodule

// File: tb/tb_mmio_slot_fabric.sv
// Randomized bench for mmio_slot_fabric against a transaction-level model of the slot map and error log.
module tb_mmio_slot_fabric;
  localparam int N = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cs = 1'b0;
  logic            rd = 1'b0;
  logic            wr = 1'b0;
  logic [20:0]     addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            rvalid;
  logic [N-1:0]    scs;
  logic [N-1:0]    srdv;
  logic [N-1:0]    swr;
  logic [4:0]      sreg;
  logic [31:0]     swd;
  logic [32*N-1:0] srd_flat;
  logic [31:0]     srd [N];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit rand_srd = 1'b1;
  logic [N-1:0] last_rd;
  logic [N-1:0] last_wr;
  logic [4:0]   last_reg;

  // Model state
  logic [31:0] m_data;
  logic        m_valid;
  int          m_cnt;
  logic [31:0] m_info;
  int          m_acc [16];
  int          ms;
  int          mr;

  mmio_slot_fabric #(.N_SLOT(N), .STAT_SLOT(63), .UNMAPPED_RD(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset(reset), .mmio_cs(cs), .mmio_wr(wr), .mmio_rd(rd),
    .mmio_addr(addr), .mmio_wr_data(wdata), .mmio_rd_data(rdata), .mmio_rd_valid(rvalid),
    .slot_cs(scs), .slot_rd(srdv), .slot_wr(swr), .slot_reg_addr(sreg),
    .slot_wr_data(swd), .slot_rd_data(srd_flat)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) srd_flat[32*i +: 32] = srd[i];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stat_val(input int r);
    if (r == 0) return 32'(m_cnt);
    if (r == 1) return m_info;
    if (r == 3) return 32'(N);
`ifdef MMIO_ACCESS_CNT_EN
    if (r >= 16 && (r - 16) < N) return 32'(m_acc[r-16]);
`endif
    return 32'h0;
  endfunction

  function automatic logic [20:0] sa(input int s, input int r);
    logic [9:0] hi;
    hi = 10'($urandom);
    return {hi, 6'(s), 5'(r)};
  endfunction

  // Transaction-level model of read port, error log and access counters.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data = '0;
      m_valid = 1'b0;
      m_cnt = 0;
      m_info = '0;
      for (int i = 0; i < 16; i++) m_acc[i] = 0;
    end else begin
      m_valid = 1'b0;
      if (cs) begin
        ms = int'(addr[10:5]);
        mr = int'(addr[4:0]);
        if (rd && !wr) begin
          m_valid = 1'b1;
          if (ms < N) m_data = srd[ms];
          else if (ms == 63) m_data = stat_val(mr);
          else m_data = 32'hFFFF_FFFF;
        end
        if (ms == 63) begin
          if (wr && mr == 2) begin
            m_cnt = 0;
            m_info = '0;
            for (int i = 0; i < 16; i++) m_acc[i] = 0;
          end
        end else begin
          if (rd && wr) m_info[30] = 1'b1;
          if (ms >= N && (rd || wr)) begin
            if (m_cnt < 65535) m_cnt++;
            m_info[31] = 1'b1;
            m_info[11] = wr;
            m_info[10:0] = addr[10:0];
          end
          if (ms < N && ms < 16 && (rd || wr) && m_acc[ms] < 65535) m_acc[ms]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(rvalid), 32'(m_valid));
      check("rd_data", rdata, m_data);
    end
  end

  // One bus cycle, starting and ending at a falling edge; strobes checked mid-cycle.
  task automatic bus(input logic c, input logic r_, input logic w, input logic [20:0] a, input logic [31:0] d);
    int s;
    logic [N-1:0] e_cs;
    cs = c; rd = r_; wr = w; addr = a; wdata = d;
    if (rand_srd) for (int i = 0; i < N; i++) srd[i] = $urandom;
    #1;
    s = int'(a[10:5]);
    for (int i = 0; i < N; i++) e_cs[i] = c && (s == i);
    check("slot_cs", 32'(scs), 32'(e_cs));
    check("slot_rd", 32'(srdv), 32'((r_ && !w) ? e_cs : '0));
    check("slot_wr", 32'(swr), 32'(w ? e_cs : '0));
    check("slot_reg_addr", 32'(sreg), 32'(a[4:0]));
    check("slot_wr_data", swd, d);
    last_rd = srdv; last_wr = swr; last_reg = sreg;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic stat_rd(input int r);
    bus(1'b1, 1'b1, 1'b0, sa(63, r), 32'h0);
  endtask

  task automatic clr();
    bus(1'b1, 1'b0, 1'b1, sa(63, 2), $urandom);
  endtask

  initial begin
    for (int i = 0; i < N; i++) srd[i] = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_data", rdata, 32'h0);
    check("reset_valid", 32'(rvalid), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    stat_rd(0);
    check("first_stat0", rdata, 32'h0);
    check("first_valid", 32'(rvalid), 32'h1);
    bus(1'b0, 1'b0, 1'b0, 21'h0, 32'h0);
    check("valid_one_cycle", 32'(rvalid), 32'h0);

    rand_srd = 1'b0;
    srd[2] = 32'hA5A5_0001;
    bus(1'b1, 1'b1, 1'b0, sa(2, 4), 32'h0);
    check("slot2_rd_strobe", 32'(last_rd), 32'h4);
    check("slot2_reg_addr", 32'(last_reg), 32'h4);
    check("slot2_data", rdata, 32'hA5A5_0001);
    check("slot2_valid", 32'(rvalid), 32'h1);
    rand_srd = 1'b1;

    bus(1'b1, 1'b0, 1'b1, sa(9, 1), 32'h1234_5678);
    check("unmapped_no_wr", 32'(last_wr), 32'h0);
    stat_rd(0);
    check("unmapped_count", rdata, 32'h1);
    stat_rd(1);
    check("unmapped_info", rdata, 32'h8000_0921);

    bus(1'b1, 1'b1, 1'b1, sa(1, 0), 32'hCAFE_0001);
    check("viol_wr", 32'(last_wr), 32'h2);
    check("viol_rd", 32'(last_rd), 32'h0);
    check("viol_no_valid", 32'(rvalid), 32'h0);
    stat_rd(1);
    check("viol_info", rdata, 32'hC000_0921);
    clr();
    stat_rd(0);
    check("clr_count", rdata, 32'h0);
    stat_rd(1);
    check("clr_info", rdata, 32'h0);
    stat_rd(3);
    check("stat_nslot", rdata, 32'h8);
    stat_rd(5);
    check("stat_other", rdata, 32'h0);
`ifndef MMIO_ACCESS_CNT_EN
    stat_rd(16);
    check("stat_cnt_absent", rdata, 32'h0);
`endif
    bus(1'b1, 1'b1, 1'b0, sa(11, 7), 32'h0);
    check("unmapped_rd_word", rdata, 32'hFFFF_FFFF);

    bus(1'b0, 1'b1, 1'b1, sa(9, 0), 32'h0);
    check("no_cs_valid", 32'(rvalid), 32'h0);

    // Reset between strobe and edge drops the pending valid.
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = sa(0, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    check("mid_reset_valid", 32'(rvalid), 32'h0);
    check("mid_reset_data", rdata, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 1500; k++) begin
      int s;
      int r;
      logic c, r_, w;
      s = ($urandom_range(0, 5) == 0) ? 63 : int'($urandom_range(0, 11));
      r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      if (s == 63 && r == 2 && $urandom_range(0, 7) != 0) r = 1;
      c = ($urandom_range(0, 7) != 0);
      r_ = 1'($urandom);
      w = 1'($urandom);
      if (s == 63 && r_ && w) w = 1'b0;
      bus(c, r_, w, sa(s, r), $urandom);
    end

    clr();
    for (int k = 0; k < 70000; k++) bus(1'b1, 1'b1, 1'b0, sa(10, 0), 32'h0);
    stat_rd(0);
    check("sat_count", rdata, 32'h0000_FFFF);
    stat_rd(1);
    check("sat_info", rdata, 32'h8000_0140);

`ifdef MMIO_ACCESS_CNT_EN
    clr();
    for (int k = 0; k < 3; k++) bus(1'b1, 1'b1, 1'b0, sa(0, k), 32'h0);
    for (int k = 0; k < 2; k++) bus(1'b1, 1'b0, 1'b1, sa(0, k), $urandom);
    stat_rd(16);
    check("acc_cnt0", rdata, 32'h5);
    bus(1'b1, 1'b1, 1'b0, sa(0, 1), 32'h0);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    stat_rd(16);
    check("acc_cnt0_reset", rdata, 32'h0);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
